lstm_gate_preact_mac: RTL and testbench

Time-multiplexed, parametrised engine that computes the LSTM gate pre-activation vector A[j] = Σi Wx[i][j]·x[i] + Σi Wh[i][j]·h_prev[i] + b[j] for j = 0..N_OUT-1. It loads x and h_prev into an internal buffer, streams weights and biases from memory through LANES parallel multiply-accumulate lanes, and emits A LANES elements per beat. It sits between the weight/activation memory subsystem and the gate nonlinearity stage of the LSTM cell. Compared with the flat combinational matrix-vector-plus-bias datapath, it adds backpressure, a skip-recurrent mode for the first timestep, fixed-point scaling and saturation.

---
 rtl/lstm_gate_preact_mac_if.sv | 33 +++
 rtl/lstm_gate_preact_mac.sv | 163 ++++++++++++++++
 tb/tb_lstm_gate_preact_mac.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lstm_gate_preact_mac_if.sv
// Handshake bundle between the LSTM gate pre-activation engine and its
// surroundings: control, activation load, weight stream and result stream.
interface lstm_gate_preact_mac_if #(
  parameter int DATA_W = 32,
  parameter int LANES  = 4
);
  logic                      start;
  logic                      use_h;
  logic                      busy;
  logic                      done;
  logic                      vec_valid;
  logic                      vec_ready;
  logic [DATA_W-1:0]         vec_data;
  logic                      w_valid;
  logic                      w_ready;
  logic [LANES*DATA_W-1:0]   w_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [LANES*DATA_W-1:0]   out_data;
  logic                      out_last;

  // Driver side: requests work, supplies activations/weights, consumes results
  modport master (
    output start, use_h, vec_valid, vec_data, w_valid, w_data, out_ready,
    input  busy, done, vec_ready, w_ready, out_valid, out_data, out_last
  );

  // Engine side
  modport slave (
    input  start, use_h, vec_valid, vec_data, w_valid, w_data, out_ready,
    output busy, done, vec_ready, w_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/lstm_gate_preact_mac.sv
// Time-multiplexed LSTM gate pre-activation engine:
// A[j] = sum_i Wx[i][j]*x[i] + sum_i Wh[i][j]*h_prev[i] + b[j],
// computed LANES outputs at a time from a streamed bias/weight sequence,
// with fixed-point rescaling and saturation on the way out.
module lstm_gate_preact_mac #(
  parameter int DATA_W = 32,
  parameter int N_IN   = 100,
  parameter int N_HID  = 100,
  parameter int N_OUT  = 400,
  parameter int LANES  = 4,
  parameter int ACC_W  = 64,
  parameter int FRAC   = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  lstm_gate_preact_mac_if.slave   io_bus
);

  localparam int N_GRP = N_OUT / LANES;
  localparam int N_BUF = N_IN + N_HID;
  localparam int IDX_W = (N_BUF > 1) ? $clog2(N_BUF) : 1;
  localparam int GRP_W = (N_GRP > 1) ? $clog2(N_GRP) : 1;
  localparam logic [IDX_W-1:0] X_LAST = IDX_W'(N_IN - 1);
  localparam logic [IDX_W-1:0] H_LAST = IDX_W'(N_BUF - 1);
  localparam logic [GRP_W-1:0] G_LAST = GRP_W'(N_GRP - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] OUT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] OUT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_X, S_LOAD_H, S_BIAS, S_MAC_X, S_MAC_H, S_OUT
  } state_t;

  state_t                    r_state;
  state_t                    w_nextState;
  logic [IDX_W-1:0]          r_idx;
  logic [GRP_W-1:0]          r_grp;
  logic                      r_useH;
  logic                      r_done;
  logic [DATA_W-1:0]         r_buf [N_BUF];
  logic signed [ACC_W-1:0]   r_acc [LANES];
  logic [LANES*DATA_W-1:0]   r_outData;

  logic                      w_busy;
  logic                      w_vecReady;
  logic                      w_wReady;
  logic                      w_outValid;
  logic                      w_outLast;
  logic                      w_vecHs;
  logic                      w_wHs;
  logic                      w_outHs;
  logic                      w_lastMac;
  logic signed [DATA_W-1:0]  w_bufVal;
  logic signed [DATA_W-1:0]  w_wLane   [LANES];
  logic signed [2*DATA_W-1:0] w_prod   [LANES];
  logic signed [ACC_W-1:0]   w_biasExt [LANES];
  logic signed [ACC_W-1:0]   w_accNext [LANES];
  logic signed [ACC_W-1:0]   w_shift   [LANES];
  logic [LANES*DATA_W-1:0]   w_satData;

  assign w_vecHs   = io_bus.vec_valid && w_vecReady;
  assign w_wHs     = io_bus.w_valid && w_wReady;
  assign w_outHs   = io_bus.out_ready && w_outValid;
  assign w_lastMac = w_wHs && (w_nextState == S_OUT);
  assign w_bufVal  = r_buf[r_idx];

  assign io_bus.busy      = w_busy;
  assign io_bus.done      = r_done;
  assign io_bus.vec_ready = w_vecReady;
  assign io_bus.w_ready   = w_wReady;
  assign io_bus.out_valid = w_outValid;
  assign io_bus.out_last  = w_outLast;
  assign io_bus.out_data  = r_outData;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nextState;
  end

  // Next-state: load x (and h), then per group bias -> MAC rows -> present result
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:   if (io_bus.start) w_nextState = S_LOAD_X;
      S_LOAD_X: if (w_vecHs && r_idx == X_LAST) w_nextState = r_useH ? S_LOAD_H : S_BIAS;
      S_LOAD_H: if (w_vecHs && r_idx == H_LAST) w_nextState = S_BIAS;
      S_BIAS:   if (w_wHs) w_nextState = S_MAC_X;
      S_MAC_X:  if (w_wHs && r_idx == X_LAST) w_nextState = r_useH ? S_MAC_H : S_OUT;
      S_MAC_H:  if (w_wHs && r_idx == H_LAST) w_nextState = S_OUT;
      S_OUT:    if (w_outHs) w_nextState = (r_grp == G_LAST) ? S_IDLE : S_BIAS;
      default:  w_nextState = S_IDLE;
    endcase
  end

  // Handshake readiness and status follow directly from the current state
  always_comb begin
    w_busy     = (r_state != S_IDLE);
    w_vecReady = (r_state == S_LOAD_X) || (r_state == S_LOAD_H);
    w_wReady   = (r_state == S_BIAS) || (r_state == S_MAC_X) || (r_state == S_MAC_H);
    w_outValid = (r_state == S_OUT);
    w_outLast  = (r_state == S_OUT) && (r_grp == G_LAST);
  end

  // Buffer/row index runs straight through x then h so one counter addresses both
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx  <= '0;
      r_grp  <= '0;
      r_useH <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_outHs && (r_grp == G_LAST);
      if (r_state == S_IDLE) begin
        r_idx <= '0;
        r_grp <= '0;
        if (io_bus.start) r_useH <= io_bus.use_h;
      end else if (w_nextState == S_BIAS || w_nextState == S_OUT) begin
        r_idx <= '0;
      end else if (w_vecHs || (w_wHs && r_state != S_BIAS)) begin
        r_idx <= r_idx + 1'b1;
      end
      if (w_outHs) r_grp <= r_grp + 1'b1;
    end
  end

  // Activation buffer holds x then h_prev; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (w_vecHs) r_buf[r_idx] <= io_bus.vec_data;
  end

  // Per-lane product, accumulate, rescale and clamp to the output range
  always_comb begin
    w_satData = '0;
    for (int k = 0; k < LANES; k++) begin
      w_wLane[k]   = io_bus.w_data[k*DATA_W +: DATA_W];
      w_prod[k]    = {{DATA_W{w_wLane[k][DATA_W-1]}}, w_wLane[k]} *
                     {{DATA_W{w_bufVal[DATA_W-1]}}, w_bufVal};
      w_biasExt[k] = {{(ACC_W-DATA_W){w_wLane[k][DATA_W-1]}}, w_wLane[k]} <<< FRAC;
      w_accNext[k] = r_acc[k] + {{(ACC_W-2*DATA_W){w_prod[k][2*DATA_W-1]}}, w_prod[k]};
      w_shift[k]   = w_accNext[k] >>> FRAC;
      if (w_shift[k] > SAT_MAX)      w_satData[k*DATA_W +: DATA_W] = OUT_MAX;
      else if (w_shift[k] < SAT_MIN) w_satData[k*DATA_W +: DATA_W] = OUT_MIN;
      else                           w_satData[k*DATA_W +: DATA_W] = w_shift[k][DATA_W-1:0];
    end
  end

  // Bias beat overwrites the accumulators; the final MAC beat also captures the result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < LANES; k++) r_acc[k] <= '0;
      r_outData <= '0;
    end else begin
      if (w_wHs) begin
        for (int k = 0; k < LANES; k++)
          r_acc[k] <= (r_state == S_BIAS) ? w_biasExt[k] : w_accNext[k];
      end
      if (w_lastMac) r_outData <= w_satData;
    end
  end

endmodule

// File: tb/tb_lstm_gate_preact_mac.sv
// Bench for lstm_gate_preact_mac: two instances (integer and FRAC=8 formats)
// share one driver; results are compared against a plain-arithmetic model.
module tb_lstm_gate_preact_mac;

  logic         clk, rst_n, sel;
  logic         start, useH, vecValid, wValid, outReady;
  logic [31:0]  vecData;
  logic [127:0] wData;
  logic         busy, done, vecReady, wReady, outValid, outLast;
  logic [127:0] outData;

  int cmpCnt = 0;
  int errCnt = 0;

  int xv [4];
  int hv [4];
  int wx [4][8];
  int wh [4][8];
  int bv [8];

  lstm_gate_preact_mac_if #(.DATA_W(32), .LANES(4)) busA ();
  lstm_gate_preact_mac_if #(.DATA_W(32), .LANES(4)) busB ();

  assign busA.start     = start & ~sel;
  assign busA.use_h     = useH;
  assign busA.vec_valid = vecValid & ~sel;
  assign busA.vec_data  = vecData;
  assign busA.w_valid   = wValid & ~sel;
  assign busA.w_data    = wData;
  assign busA.out_ready = outReady & ~sel;
  assign busB.start     = start & sel;
  assign busB.use_h     = useH;
  assign busB.vec_valid = vecValid & sel;
  assign busB.vec_data  = vecData;
  assign busB.w_valid   = wValid & sel;
  assign busB.w_data    = wData;
  assign busB.out_ready = outReady & sel;

  assign busy     = sel ? busB.busy      : busA.busy;
  assign done     = sel ? busB.done      : busA.done;
  assign vecReady = sel ? busB.vec_ready : busA.vec_ready;
  assign wReady   = sel ? busB.w_ready   : busA.w_ready;
  assign outValid = sel ? busB.out_valid : busA.out_valid;
  assign outLast  = sel ? busB.out_last  : busA.out_last;
  assign outData  = sel ? busB.out_data  : busA.out_data;

  lstm_gate_preact_mac #(.DATA_W(32), .N_IN(4), .N_HID(4), .N_OUT(8), .LANES(4),
                         .ACC_W(64), .FRAC(0))
    dutA (.clk(clk), .rst_n(rst_n), .io_bus(busA));

  lstm_gate_preact_mac #(.DATA_W(32), .N_IN(1), .N_HID(1), .N_OUT(4), .LANES(4),
                         .ACC_W(64), .FRAC(8))
    dutB (.clk(clk), .rst_n(rst_n), .io_bus(busB));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    cmpCnt++;
    assert (obs === exp) else begin
      errCnt++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rnd();
    int v;
    if ($urandom_range(0, 3) == 0) v = int'($urandom);
    else v = int'($urandom_range(0, 65535)) - 32768;
    return v;
  endfunction

  // Golden result: dot products plus scaled bias, then rescale and clamp
  function automatic logic [31:0] refA(int j, bit uh, int nIn, int nHid, int frac);
    longint acc;
    if (j > 7) return 32'h0;
    acc = longint'(bv[j]) <<< frac;
    for (int i = 0; i < nIn; i++) acc += longint'(wx[i][j]) * longint'(xv[i]);
    if (uh) for (int i = 0; i < nHid; i++) acc += longint'(wh[i][j]) * longint'(hv[i]);
    acc = acc >>> frac;
    if (acc > 64'sd2147483647)  return 32'h7fff_ffff;
    if (acc < -64'sd2147483648) return 32'h8000_0000;
    return acc[31:0];
  endfunction

  // Weight stream beat p: per group one bias row, nIn Wx rows, then Wh rows
  function automatic logic [127:0] wBeat(int p, int bpg, int nIn);
    int g, t, j;
    logic [127:0] r;
    g = p / bpg;
    t = p % bpg;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      j = g * 4 + k;
      if (t == 0)         r[k*32 +: 32] = bv[j];
      else if (t <= nIn)  r[k*32 +: 32] = wx[t-1][j];
      else                r[k*32 +: 32] = wh[t-1-nIn][j];
    end
    return r;
  endfunction

  task automatic setPattern(input int mode);
    for (int i = 0; i < 4; i++) begin
      xv[i] = 0;
      hv[i] = 0;
      for (int j = 0; j < 8; j++) begin
        wx[i][j] = 0;
        wh[i][j] = 0;
      end
    end
    for (int j = 0; j < 8; j++) bv[j] = 0;
    case (mode)
      0: begin
        for (int i = 0; i < 4; i++) begin
          xv[i] = i + 1;
          hv[i] = 1;
          for (int j = 0; j < 8; j++) begin
            wx[i][j] = 1;
            wh[i][j] = 2;
          end
        end
        for (int j = 0; j < 8; j++) bv[j] = 5;
      end
      1, 2: begin
        xv[0] = 1 << 30;
        for (int j = 0; j < 8; j++) wx[0][j] = (mode == 1) ? 4 : -4;
      end
      3: begin
        for (int i = 0; i < 4; i++) begin
          xv[i] = rnd();
          hv[i] = rnd();
          for (int j = 0; j < 8; j++) begin
            wx[i][j] = rnd();
            wh[i][j] = rnd();
          end
        end
        for (int j = 0; j < 8; j++) bv[j] = rnd();
      end
      4: begin
        xv[0] = 256;
        for (int j = 0; j < 8; j++) begin
          wx[0][j] = 512;
          bv[j] = 128;
        end
      end
      default: begin
        xv[0] = 1;
        for (int j = 0; j < 8; j++) wx[0][j] = -1;
      end
    endcase
  endtask

  // One complete job on the selected instance with optional gaps, output stall,
  // a stray start pulse at a given cycle, or a reset after a given weight beat
  task automatic applyStimulus(input bit selB, input bit uh, input int gapPct,
                               input int stallCyc, input int dupStartCyc, input int abortBeat);
    int nIn, nHid, nGrp, frac, bpg, nVec, vecPtr, wPtr, outGrp, cyc, stallLeft;
    bit finished, seenGrp, vecDropChk, expectOut, lastHs;
    logic [127:0] held;
    nIn = selB ? 1 : 4;
    nHid = selB ? 1 : 4;
    nGrp = selB ? 1 : 2;
    frac = selB ? 8 : 0;
    bpg = 1 + nIn + (uh ? nHid : 0);
    nVec = nIn + (uh ? nHid : 0);
    vecPtr = 0; wPtr = 0; outGrp = 0; cyc = 0; stallLeft = stallCyc;
    finished = 0; seenGrp = 0; vecDropChk = 0; expectOut = 0; lastHs = 0;
    held = '0;
    sel = selB;
    @(negedge clk);
    start = 1'b1;
    useH = uh;
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy_rise", busy, 1'b1);
    checkOutput("vec_ready_first", vecReady, 1'b1);
    while (!finished && cyc < 3000) begin
      if (abortBeat >= 0 && wPtr == abortBeat) begin
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", busy, 1'b0);
        checkOutput("abort_done", done, 1'b0);
        checkOutput("abort_vec_ready", vecReady, 1'b0);
        checkOutput("abort_w_ready", wReady, 1'b0);
        checkOutput("abort_out_valid", outValid, 1'b0);
        checkOutput("abort_out_last", outLast, 1'b0);
        checkOutput("abort_out_data", outData, 128'h0);
        vecValid = 1'b0; wValid = 1'b0; outReady = 1'b0; start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (lastHs) begin
        checkOutput("done_pulse", done, 1'b1);
        checkOutput("busy_fall", busy, 1'b0);
        finished = 1;
      end else begin
        if (done) checkOutput("done_early", done, 1'b0);
        if (expectOut) begin
          checkOutput("out_valid_rise", outValid, 1'b1);
          expectOut = 0;
        end
        if (vecPtr == nVec && !vecDropChk) begin
          checkOutput("vec_ready_drop", vecReady, 1'b0);
          vecDropChk = 1;
        end
        if (outValid) begin
          if (!seenGrp) begin
            for (int k = 0; k < 4; k++)
              checkOutput($sformatf("A[%0d]", outGrp * 4 + k), outData[k*32 +: 32],
                          refA(outGrp * 4 + k, uh, nIn, nHid, frac));
            checkOutput("out_last", outLast, (outGrp == nGrp - 1));
            held = outData;
            seenGrp = 1;
          end else begin
            checkOutput("out_hold", outData, held);
            checkOutput("w_ready_stall", wReady, 1'b0);
          end
          if (stallLeft > 0) begin
            outReady = 1'b0;
            stallLeft--;
          end else begin
            outReady = (gapPct == 0) ? 1'b1 : 1'($urandom_range(0, 1));
          end
          if (outReady) begin
            outGrp++;
            seenGrp = 0;
            lastHs = (outGrp == nGrp);
          end
        end else begin
          outReady = 1'($urandom_range(0, 1));
        end
        if (vecPtr < nVec && $urandom_range(0, 99) >= gapPct) begin
          vecValid = 1'b1;
          vecData = (vecPtr < nIn) ? xv[vecPtr] : hv[vecPtr - nIn];
        end else begin
          vecValid = (vecPtr >= nVec) ? 1'($urandom_range(0, 1)) : 1'b0;
          vecData = $urandom;
        end
        if (vecValid && vecReady && vecPtr < nVec) vecPtr++;
        if (wPtr < nGrp * bpg && $urandom_range(0, 99) >= gapPct) begin
          wValid = 1'b1;
          wData = wBeat(wPtr, bpg, nIn);
        end else begin
          wValid = (wPtr >= nGrp * bpg) ? 1'($urandom_range(0, 1)) : 1'b0;
          wData = {$urandom, $urandom, $urandom, $urandom};
        end
        if (wValid && wReady && wPtr < nGrp * bpg) begin
          wPtr++;
          if (wPtr % bpg == 0) expectOut = 1;
        end
        start = (cyc == dupStartCyc);
        @(negedge clk);
        cyc++;
      end
    end
    checkOutput("job_complete", finished, 1'b1);
    vecValid = 1'b0; wValid = 1'b0; outReady = 1'b0; start = 1'b0;
    @(negedge clk);
    checkOutput("done_clear", done, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; sel = 1'b0; start = 1'b0; useH = 1'b0;
    vecValid = 1'b0; wValid = 1'b0; outReady = 1'b0;
    vecData = '0; wData = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_vec_ready", vecReady, 1'b0);
    checkOutput("rst_w_ready", wReady, 1'b0);
    checkOutput("rst_out_valid", outValid, 1'b0);
    checkOutput("rst_out_last", outLast, 1'b0);
    checkOutput("rst_out_data", outData, 128'h0);
    sel = 1'b1;
    #1;
    checkOutput("rst_b_out_valid", outValid, 1'b0);
    checkOutput("rst_b_out_data", outData, 128'h0);
    sel = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] basic run with recurrent term");
    setPattern(0);
    applyStimulus(0, 1, 0, 0, -1, -1);
    $display("[TB] skip-recurrent run");
    applyStimulus(0, 0, 0, 0, -1, -1);
    $display("[TB] saturation runs");
    setPattern(1);
    applyStimulus(0, 1, 0, 0, -1, -1);
    setPattern(2);
    applyStimulus(0, 0, 0, 0, -1, -1);
    $display("[TB] random data with backpressure");
    for (int r = 0; r < 3; r++) begin
      setPattern(3);
      applyStimulus(0, 1'(r % 2 == 0), 30, 10, -1, -1);
    end
    $display("[TB] start pulsed while busy");
    setPattern(3);
    applyStimulus(0, 1, 20, 0, 5, -1);
    $display("[TB] reset in the middle of the x products");
    setPattern(3);
    applyStimulus(0, 1, 0, 0, -1, 3);
    setPattern(3);
    applyStimulus(0, 1, 25, 3, -1, -1);
    $display("[TB] fixed-point instance");
    setPattern(4);
    applyStimulus(1, 0, 0, 0, -1, -1);
    setPattern(5);
    applyStimulus(1, 0, 0, 0, -1, -1);
    setPattern(3);
    applyStimulus(1, 1, 30, 4, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCnt, errCnt);
    $finish;
  end

endmodule
